// File: rtl/cache_op_ctrl.sv
// CACHE-instruction sequencer: decodes one latched op and issues it to the I or D cache via req/ack/done.
// Optional watchdog enabled by defining CACHE_OP_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module cache_op_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [1:0]  req_target,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_paddr,
  output logic        op_done,
  output logic        busy,
  output logic        ic_req,
  output logic [2:0]  ic_cmd,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic        ic_done,
  output logic        dc_req,
  output logic [2:0]  dc_cmd,
  output logic [31:0] dc_addr,
  input  logic        dc_ack,
  input  logic        dc_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cmd_q;
  logic [31:0] addr_q;
  logic        sel_dc_q;
  logic        req_q;
  logic        killed, killed_nxt;
  logic        accept;
  logic [2:0]  dec_cmd;
  logic        dec_ok;
  logic        ack_sel, done_sel;
  logic        unused_cache_field;

  // op[1:0] names the cache in the MIPS encoding; req_target already carries that choice
  assign unused_cache_field = ^req_op[1:0];

  always_comb begin
    dec_cmd = 3'd0;
    dec_ok  = 1'b0;
    if (req_target == 2'b01 || req_target == 2'b10) begin
      case (req_op[4:2])
        3'b000:  begin dec_cmd = 3'd1; dec_ok = 1'b1; end
        3'b010:  begin dec_cmd = 3'd2; dec_ok = 1'b1; end
        3'b100:  begin dec_cmd = 3'd3; dec_ok = 1'b1; end
        3'b101:  begin dec_cmd = 3'd4; dec_ok = req_target[1]; end
        3'b110:  begin dec_cmd = 3'd5; dec_ok = req_target[1]; end
        default: begin dec_cmd = 3'd0; dec_ok = 1'b0; end
      endcase
    end
  end

  // ack only counts once the request is actually visible to the cache
  assign ack_sel  = req_q & (sel_dc_q ? dc_ack : ic_ack);
  assign done_sel = sel_dc_q ? dc_done : ic_done;

`ifdef CACHE_OP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit, tmo_fire, tmo_err_q;

  assign tmo_hit = ((state == S_REQ) || (state == S_WAIT)) &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state == S_IDLE)
        cnt <= '0;
      else if (state == S_REQ || state == S_WAIT)
        cnt <= cnt + 1'b1;
      if (tmo_fire)
        tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    killed_nxt = killed;
    accept     = 1'b0;
`ifdef CACHE_OP_TIMEOUT_EN
    tmo_fire   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        killed_nxt = 1'b0;
        if (req_target != 2'b00 && !flush) begin
          accept    = 1'b1;
          state_nxt = dec_ok ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (flush && !ack_sel)
          state_nxt = S_IDLE;
        else if (ack_sel && done_sel)
          state_nxt = (flush || killed) ? S_IDLE : S_DONE;
        else if (ack_sel) begin
          state_nxt  = S_WAIT;
          killed_nxt = flush;
        end
`ifdef CACHE_OP_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = killed ? S_IDLE : S_DONE;
        end
`endif
      end
      S_WAIT: begin
        killed_nxt = killed | flush;
        if (done_sel)
          state_nxt = (killed || flush) ? S_IDLE : S_DONE;
`ifdef CACHE_OP_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = (killed || flush) ? S_IDLE : S_DONE;
        end
`endif
      end
      S_DONE: begin
        killed_nxt = 1'b0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      killed   <= 1'b0;
      req_q    <= 1'b0;
      cmd_q    <= 3'd0;
      addr_q   <= 32'd0;
      sel_dc_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      killed <= killed_nxt;
      // req rises on the second REQ cycle and falls as soon as REQ is left
      req_q  <= (state == S_REQ) && (state_nxt == S_REQ);
      if (accept) begin
        cmd_q    <= dec_ok ? dec_cmd : 3'd0;
        addr_q   <= req_paddr;
        sel_dc_q <= req_target[1];
      end
    end
  end

  assign op_done = (state == S_DONE);
  assign busy    = (state != S_IDLE);
  assign ic_req  = req_q & ~sel_dc_q;
  assign dc_req  = req_q & sel_dc_q;
  assign ic_cmd  = cmd_q;
  assign dc_cmd  = cmd_q;
  assign ic_addr = addr_q;
  assign dc_addr = addr_q;

endmodule
